// File: rtl/serial_add_scheduler_if.sv
// Bundle of requester, serial-adder and result signals for serial_add_scheduler.
// The scheduler takes the slave view. Requesters, the adder and the consumer take the master view.
interface serial_add_scheduler_if #(
    parameter int W = 8
);
    logic         req0_vld;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_rdy;
    logic         req1_vld;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_rdy;
    logic         add_vld;
    logic         add_a;
    logic         add_b;
    logic         add_last;
    logic         add_sum;
    logic         res_vld;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_rdy;

    modport slave (
        input  req0_vld, req0_a, req0_b, req1_vld, req1_a, req1_b, add_sum, res_rdy,
        output req0_rdy, req1_rdy, add_vld, add_a, add_b, add_last, res_vld, res_id, res_sum
    );

    modport master (
        output req0_vld, req0_a, req0_b, req1_vld, req1_a, req1_b, add_sum, res_rdy,
        input  req0_rdy, req1_rdy, add_vld, add_a, add_b, add_last, res_vld, res_id, res_sum
    );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that lets two parallel requesters share one bit-serial adder.
// Operands are sent LSB-first. The sum bits are gathered into a parallel result that is held until the consumer accepts it.
module serial_add_scheduler #(
    parameter int W = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_scheduler_if.slave bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          res_id_q, res_id_d;
    logic          rdy0, rdy1;

    always_comb begin
        // When both requesters are valid, the one that did not win last time gets the grant.
        rdy0 = (state_q == IDLE) && bus.req0_vld && (!bus.req1_vld || last_grant_q);
        rdy1 = (state_q == IDLE) && bus.req1_vld && (!bus.req0_vld || !last_grant_q);

        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        res_id_d     = res_id_q;

        case (state_q)
            IDLE: begin
                if (rdy0 || rdy1) begin
                    a_d          = rdy1 ? bus.req1_a : bus.req0_a;
                    b_d          = rdy1 ? bus.req1_b : bus.req0_b;
                    last_grant_d = rdy1;
                    res_id_d     = rdy1;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bus.add_sum, res_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            res_id_q     <= res_id_d;
        end
    end

    assign bus.req0_rdy = rdy0;
    assign bus.req1_rdy = rdy1;
    assign bus.add_vld  = (state_q == SHIFT);
    assign bus.add_a    = (state_q == SHIFT) && a_q[0];
    assign bus.add_b    = (state_q == SHIFT) && b_q[0];
    assign bus.add_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign bus.res_vld  = (state_q == DONE);
    assign bus.res_id   = res_id_q;
    assign bus.res_sum  = res_q;
endmodule
